// File: rtl/level_result_collector_if.sv
// level_result_collector_if: request/level/forward/result signals of the collector; slave = collector side, master = environment side
interface level_result_collector_if #(
  parameter int POINTER_SIZE = 16,
  parameter int TAG_SIZE = 8,
  parameter int CNT_SIZE = 16
);
  logic req_valid_in;
  logic [TAG_SIZE-1:0] req_tag_in;
  logic [POINTER_SIZE-1:0] req_address_in;
  logic [POINTER_SIZE-1:0] lvl_next_pointer_in;
  logic lvl_is_match_in;
  logic lvl_no_child_in;
  logic fwd_valid_out;
  logic [TAG_SIZE-1:0] fwd_tag_out;
  logic [POINTER_SIZE-1:0] fwd_address_out;
  logic res_valid_out;
  logic res_ready_in;
  logic [TAG_SIZE-1:0] res_tag_out;
  logic res_hit_out;
  logic [POINTER_SIZE-1:0] res_pointer_out;
  logic [7:0] res_level_out;
  logic [CNT_SIZE-1:0] hit_count_out;
  logic [CNT_SIZE-1:0] miss_count_out;
  logic overflow_out;
  modport master (
    output req_valid_in, req_tag_in, req_address_in, lvl_next_pointer_in, lvl_is_match_in, lvl_no_child_in, res_ready_in,
    input fwd_valid_out, fwd_tag_out, fwd_address_out, res_valid_out, res_tag_out, res_hit_out, res_pointer_out,
    input res_level_out, hit_count_out, miss_count_out, overflow_out
  );
  modport slave (
    input req_valid_in, req_tag_in, req_address_in, lvl_next_pointer_in, lvl_is_match_in, lvl_no_child_in, res_ready_in,
    output fwd_valid_out, fwd_tag_out, fwd_address_out, res_valid_out, res_tag_out, res_hit_out, res_pointer_out,
    output res_level_out, hit_count_out, miss_count_out, overflow_out
  );
endinterface

// File: rtl/level_result_collector.sv
// level_result_collector: aligns lookup sideband with level outputs, forwards CONTINUE lookups, buffers HIT/MISS in a FIFO with saturating counters (ports: clk, rst_n, bus slave)
module level_result_collector #(
  parameter int POINTER_SIZE = 16,
  parameter int WORD_SIZE = 16,
  parameter int TAG_SIZE = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LEVEL_ID = 1,
  parameter int CNT_SIZE = 16
) (
  input logic clk,
  input logic rst_n,
  level_result_collector_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = TAG_SIZE + 1 + POINTER_SIZE;
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WORD_SIZE < 1) begin : g_bad_params
    $error("level_result_collector: FIFO_DEPTH must be a power of two >= 2 and WORD_SIZE >= 1");
  end
  logic a_valid_q, a_valid_d;
  logic [TAG_SIZE-1:0] a_tag_q, a_tag_d;
  logic [POINTER_SIZE-1:0] a_addr_q, a_addr_d;
  logic fwd_valid_q, fwd_valid_d;
  logic [TAG_SIZE-1:0] fwd_tag_q, fwd_tag_d;
  logic [POINTER_SIZE-1:0] fwd_addr_q, fwd_addr_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [CNT_SIZE-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic ovf_q, ovf_d;
  logic is_hit, is_miss, is_cont, push, pop, full, accept;
  logic [EW-1:0] head;
  always_comb begin
    is_hit = a_valid_q & bus.lvl_is_match_in;
    is_miss = a_valid_q & ~bus.lvl_is_match_in & bus.lvl_no_child_in;
    is_cont = a_valid_q & ~bus.lvl_is_match_in & ~bus.lvl_no_child_in;
    push = is_hit | is_miss;
    pop = (cnt_q != '0) & bus.res_ready_in;
    full = cnt_q == (AW + 1)'(FIFO_DEPTH);
    accept = push & (~full | pop);
    a_valid_d = bus.req_valid_in;
    a_tag_d = bus.req_tag_in;
    a_addr_d = bus.req_address_in;
    fwd_valid_d = is_cont;
    fwd_tag_d = is_cont ? a_tag_q : fwd_tag_q;
    fwd_addr_d = is_cont ? bus.lvl_next_pointer_in : fwd_addr_q;
    mem_d = mem_q;
    mem_d[wr_q] = accept ? {a_tag_q, is_hit, a_addr_q} : mem_q[wr_q];
    wr_d = wr_q + AW'(accept);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW + 1)'(accept) - (AW + 1)'(pop);
    hit_cnt_d = hit_cnt_q + CNT_SIZE'(accept & is_hit & ~&hit_cnt_q);
    miss_cnt_d = miss_cnt_q + CNT_SIZE'(accept & is_miss & ~&miss_cnt_q);
    ovf_d = ovf_q | (push & ~accept);
    head = mem_q[rd_q];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_tag_q <= '0;
      a_addr_q <= '0;
      fwd_valid_q <= 1'b0;
      fwd_tag_q <= '0;
      fwd_addr_q <= '0;
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_tag_q <= a_tag_d;
      a_addr_q <= a_addr_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_tag_q <= fwd_tag_d;
      fwd_addr_q <= fwd_addr_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.fwd_valid_out = fwd_valid_q;
  assign bus.fwd_tag_out = fwd_tag_q;
  assign bus.fwd_address_out = fwd_addr_q;
  assign bus.res_valid_out = cnt_q != '0;
  assign {bus.res_tag_out, bus.res_hit_out, bus.res_pointer_out} = head;
  assign bus.res_level_out = (cnt_q != '0) ? 8'(LEVEL_ID) : 8'd0;
  assign bus.hit_count_out = hit_cnt_q;
  assign bus.miss_count_out = miss_cnt_q;
  assign bus.overflow_out = ovf_q;
endmodule
